frame_monitor: RTL and testbench

//  Passive checker sitting directly downstream of the Ethernet frame generator FSM.

---
 rtl/frame_monitor.sv | 178 +++++++++++++++++
 tb/tb_frame_monitor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_monitor.sv
// Passive checker behind the Ethernet frame generator: verifies field order and
// durations, measures data length, recomputes the CRC and keeps frame statistics.
module frame_monitor #(
  parameter int unsigned MIN_LEN = 46,
  parameter int unsigned MAX_LEN = 1500,
  parameter int unsigned MIN_IGP = 12
) (
  input  logic        iclk,
  input  logic        irst_n,
  input  logic [2:0]  ist,
  input  logic [7:0]  idata_byte,
  output logic        oframe_done,
  output logic [10:0] olen,
  output logic [31:0] ocrc,
  output logic [3:0]  oerr_flags,
  output logic [15:0] oframe_cnt,
  output logic [15:0] oerr_cnt
);

  localparam logic [2:0] S_IGP = 3'd0, S_PRE = 3'd1, S_SFD = 3'd2, S_DA = 3'd3,
                         S_SA  = 3'd4, S_LT  = 3'd5, S_DATA = 3'd6, S_FCS = 3'd7;
  localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);
  localparam logic [10:0] MAX_LEN_C = 11'(MAX_LEN);
  localparam logic [10:0] MIN_IGP_C = 11'(MIN_IGP);

  typedef enum logic [1:0] {HUNT, FRAME, IGPW} mon_st_e;

  // Non-reflected CRC-32, MSB of the byte first; equivalent to the D8 parallel form.
  function automatic logic [31:0] crc_d8(input logic [7:0] d, input logic [31:0] c);
    logic [31:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h04C1_1DB7;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [10:0] field_len(input logic [2:0] s);
    case (s)
      S_PRE:   field_len = 11'd7;
      S_SFD:   field_len = 11'd1;
      S_DA:    field_len = 11'd6;
      S_SA:    field_len = 11'd6;
      S_LT:    field_len = 11'd2;
      S_FCS:   field_len = 11'd4;
      default: field_len = 11'd0;
    endcase
  endfunction

  mon_st_e     state_q, state_d;
  logic [2:0]  prev_st_q;
  logic [10:0] run_q, run_d;
  logic [3:0]  flags_q, flags_d, flags_fin;
  logic [31:0] crc_q, crc_d;
  logic [10:0] len_q, len_d;
  logic        done_d;

  logic        done_q;
  logic [10:0] olen_q;
  logic [31:0] ocrc_q;
  logic [3:0]  oflags_q;
  logic [15:0] fcnt_q, ecnt_q;

  logic        chg, legal;
  logic [2:0]  succ;
  logic [3:0]  exit_bits;

  assign chg   = (ist != prev_st_q);
  assign succ  = prev_st_q + 3'd1;
  assign legal = (ist == succ);

  // Length check of the run that ends on this cycle's transition.
  always_comb begin
    exit_bits = 4'b0000;
    if (prev_st_q == S_DATA) begin
      if (len_q < MIN_LEN_C || len_q > MAX_LEN_C) exit_bits[2] = 1'b1;
    end else if (prev_st_q != S_IGP) begin
      if (run_q != field_len(prev_st_q)) exit_bits[1] = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    flags_d   = flags_q;
    flags_fin = flags_q;
    crc_d     = crc_q;
    len_d     = len_q;
    done_d    = 1'b0;
    run_d     = chg ? 11'd1 : ((run_q == 11'h7FF) ? run_q : run_q + 11'd1);

    case (state_q)
      HUNT: begin
        if (chg && prev_st_q == S_IGP && ist == S_PRE) begin
          state_d = FRAME;
          flags_d = 4'b0000;
          crc_d   = 32'd0;
          len_d   = 11'd0;
        end
      end
      FRAME: begin
        if (chg && (!legal || prev_st_q == S_FCS)) begin
          flags_fin = flags_q | exit_bits | {3'b000, ~legal};
          done_d    = 1'b1;
          flags_d   = 4'b0000;
          state_d   = legal ? IGPW : HUNT;
        end else begin
          if (chg) flags_d = flags_q | exit_bits;
          if (ist == S_DATA) begin
            crc_d = crc_d8(idata_byte, crc_q);
            if (len_q != 11'h7FF) len_d = len_q + 11'd1;
          end else if (ist == S_FCS) begin
            crc_d = crc_d8(8'h00, crc_q);
          end
        end
      end
      IGPW: begin
        if (chg) begin
          if (prev_st_q == S_IGP && ist == S_PRE) begin
            state_d = FRAME;
            flags_d = {(run_q < MIN_IGP_C), 3'b000};
            crc_d   = 32'd0;
            len_d   = 11'd0;
          end else begin
            flags_fin = flags_q | 4'b0001;
            done_d    = 1'b1;
            flags_d   = 4'b0000;
            state_d   = HUNT;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q   <= HUNT;
      prev_st_q <= S_IGP;
      run_q     <= 11'd0;
      flags_q   <= 4'b0000;
      crc_q     <= 32'd0;
      len_q     <= 11'd0;
      done_q    <= 1'b0;
      olen_q    <= 11'd0;
      ocrc_q    <= 32'd0;
      oflags_q  <= 4'b0000;
      fcnt_q    <= 16'd0;
      ecnt_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      prev_st_q <= ist;
      run_q     <= run_d;
      flags_q   <= flags_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      done_q    <= done_d;
      if (done_d) begin
        olen_q   <= len_q;
        ocrc_q   <= crc_q;
        oflags_q <= flags_fin;
        if (flags_fin == 4'b0000) begin
          if (fcnt_q != 16'hFFFF) fcnt_q <= fcnt_q + 16'd1;
        end else begin
          if (ecnt_q != 16'hFFFF) ecnt_q <= ecnt_q + 16'd1;
        end
      end
    end
  end

  assign oframe_done = done_q;
  assign olen        = olen_q;
  assign ocrc        = ocrc_q;
  assign oerr_flags  = oflags_q;
  assign oframe_cnt  = fcnt_q;
  assign oerr_cnt    = ecnt_q;

endmodule

// File: tb/tb_frame_monitor.sv
// Scoreboard bench for frame_monitor: directed frames push expected reports,
// a negedge monitor pops and compares on every oframe_done pulse.
module tb_frame_monitor;

  logic        iclk = 1'b0;
  logic        irst_n = 1'b0;
  logic [2:0]  ist = 3'd0;
  logic [7:0]  idata_byte = 8'd0;
  logic        oframe_done;
  logic [10:0] olen;
  logic [31:0] ocrc;
  logic [3:0]  oerr_flags;
  logic [15:0] oframe_cnt, oerr_cnt;

  frame_monitor dut (
    .iclk(iclk), .irst_n(irst_n), .ist(ist), .idata_byte(idata_byte),
    .oframe_done(oframe_done), .olen(olen), .ocrc(ocrc), .oerr_flags(oerr_flags),
    .oframe_cnt(oframe_cnt), .oerr_cnt(oerr_cnt)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    logic [10:0] len;
    logic [31:0] crc;
    logic [3:0]  flags;
    logic [15:0] fc;
    logic [15:0] ec;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [15:0] mfc = 16'd0, mec = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference CRC-32 step: poly 04C11DB7, MSB first, no reflection.
  function automatic logic [31:0] crc_step(input logic [7:0] d, input logic [31:0] c);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[31] ^ d[i];
      r  = r << 1;
      if (fb) r = r ^ 32'h04C1_1DB7;
    end
    return r;
  endfunction

  task automatic tick(input logic [2:0] s, input logic [7:0] d);
    ist = s;
    idata_byte = d;
    @(posedge iclk);
    #1;
  endtask

  task automatic run(input logic [2:0] s, input int n);
    for (int i = 0; i < n; i++) tick(s, 8'(i * 7 + 3));
  endtask

  task automatic push(input logic [10:0] len, input logic [31:0] crc, input logic [3:0] flags);
    exp_t e;
    if (flags == 4'b0000) mfc = mfc + 16'd1;
    else                  mec = mec + 16'd1;
    e.len = len; e.crc = crc; e.flags = flags; e.fc = mfc; e.ec = mec;
    q.push_back(e);
  endtask

  // mode 0: zero payload, mode 1: bytes 0,1,2,...
  task automatic frame(input int pre, input int n, input int mode, input logic [3:0] exp_flags);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'd0;
    run(3'd1, pre);
    run(3'd2, 1);
    run(3'd3, 6);
    run(3'd4, 6);
    run(3'd5, 2);
    for (int i = 0; i < n; i++) begin
      b = (mode == 1) ? 8'(i) : 8'h00;
      c = crc_step(b, c);
      tick(3'd6, b);
    end
    for (int i = 0; i < 4; i++) begin
      c = crc_step(8'h00, c);
      tick(3'd7, 8'hA5);
    end
    push(11'(n), c, exp_flags);
  endtask

  initial begin : monitor
    exp_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge iclk);
      if (oframe_done) begin
        chk("pulse_width", {31'd0, prev_done}, 32'd0);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got pulse, expected none (len %0d flags %b)", olen, oerr_flags);
        end else begin
          e = q.pop_front();
          chk("olen",       32'(olen),       32'(e.len));
          chk("ocrc",       ocrc,            e.crc);
          chk("oerr_flags", 32'(oerr_flags), 32'(e.flags));
          chk("oframe_cnt", 32'(oframe_cnt), 32'(e.fc));
          chk("oerr_cnt",   32'(oerr_cnt),   32'(e.ec));
        end
      end
      prev_done = oframe_done;
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge iclk);
      n++;
    end
    #1;
    chk(name, 32'(q.size()), 32'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_done"},  32'(oframe_done), 32'd0);
    chk({tag, "_len"},   32'(olen),        32'd0);
    chk({tag, "_crc"},   ocrc,             32'd0);
    chk({tag, "_flags"}, 32'(oerr_flags),  32'd0);
    chk({tag, "_fcnt"},  32'(oframe_cnt),  32'd0);
    chk({tag, "_ecnt"},  32'(oerr_cnt),    32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (3) @(posedge iclk);
    #1;
    chk_idle("reset");
    irst_n = 1'b1;

    // 1: minimum-length frame of zeros
    run(3'd0, 12);
    frame(7, 46, 0, 4'b0000);
    run(3'd0, 12);
    // 2: 64 incrementing bytes
    frame(7, 64, 1, 4'b0000);
    run(3'd0, 12);
    // 3: short preamble
    frame(6, 46, 0, 4'b0010);
    run(3'd0, 12);
    // 4: data length below and above range
    frame(7, 20, 0, 4'b0100);
    run(3'd0, 12);
    frame(7, 1501, 0, 4'b0100);
    run(3'd0, 12);
    // 5: short IGP between frames
    frame(7, 46, 1, 4'b0000);
    run(3'd0, 8);
    frame(7, 46, 1, 4'b1000);
    run(3'd0, 12);
    // 6: SADDR -> DATA jump, then recovery
    run(3'd1, 7);
    run(3'd2, 1);
    run(3'd3, 6);
    run(3'd4, 6);
    push(11'd0, 32'd0, 4'b0001);
    run(3'd6, 5);
    run(3'd0, 12);
    frame(7, 50, 1, 4'b0000);
    run(3'd0, 12);
    drain("queue_empty_before_reset");

    // 6b: reset in the middle of DATA
    run(3'd1, 7);
    run(3'd2, 1);
    run(3'd3, 6);
    run(3'd4, 6);
    run(3'd5, 2);
    run(3'd6, 10);
    irst_n = 1'b0;
    #1;
    chk_idle("midreset");
    mfc = 16'd0;
    mec = 16'd0;
    run(3'd6, 3);
    irst_n = 1'b1;
    run(3'd6, 40);
    run(3'd7, 4);
    run(3'd0, 12);
    chk("post_reset_fcnt", 32'(oframe_cnt), 32'd0);
    chk("post_reset_ecnt", 32'(oerr_cnt),   32'd0);
    chk("post_reset_queue", 32'(q.size()),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
